// File: rtl/key_word_loader_if.sv
// Word-stream handshake between a firmware/bus feeder and the key word loader.
interface key_word_loader_if #(
  parameter int DW = 32
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DW-1:0]     wr_data;
  logic [DW/8-1:0]   wr_par;

  modport master (output wr_valid, output wr_data, output wr_par, input wr_ready);
  modport slave  (input wr_valid, input wr_data, input wr_par, output wr_ready);
endinterface

// File: rtl/key_word_loader.sv
// Key word loader: collects DW-bit parity-protected words into a W-bit staging
// buffer and hands the full key to the key register as a single-cycle load
// strobe. Any parity error, inter-word timeout or zeroize wipes the buffer.
module key_word_loader #(
  parameter int W       = 128,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  key_word_loader_if.slave     bus,
  input  logic                 zeroize,
  output logic                 load,
  output logic [W-1:0]         key_out,
  output logic                 busy,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam int N     = W / DW;
  localparam int NB    = DW / 8;
  localparam int CNT_W = $clog2(N + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;
  localparam logic [1:0] WIPE    = 2'd3;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_TMO    = 2'b10;
  localparam logic [1:0] ERR_ZERO   = 2'b11;

  logic [1:0]       state_q;
  logic [W-1:0]     stage_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TMO_W-1:0] tmo_q;
  logic             par_ok;
  logic             accept;
  logic             last_word;
  logic             timeout_hit;

  // Odd parity per byte lane: every {par, byte} group must XOR to 1.
  always_comb begin
    // NOTE: default first, so no path through the loop leaves par_ok unassigned (no latch).
    par_ok = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (^{bus.wr_par[i], bus.wr_data[8*i +: 8]} != 1'b1) par_ok = 1'b0;
    end
  end

  assign bus.wr_ready = ((state_q == IDLE) || (state_q == COLLECT)) && !zeroize;
  assign accept       = bus.wr_valid && bus.wr_ready;
  assign last_word    = (cnt_q == CNT_W'(N - 1));
  assign timeout_hit  = (state_q == COLLECT) && !accept && (tmo_q == TMO_W'(TIMEOUT - 1));

  // The key is only visible during the commit cycle, and zeroize masks it at once.
  assign load     = (state_q == COMMIT) && !zeroize;
  assign key_out  = load ? stage_q : '0;
  assign busy     = (state_q != IDLE);

  // Transfer FSM, staging buffer, word index, idle counter and sticky error.
  // NOTE: the staging buffer is ordinary flops holding key material, so it is
  // reset along with the control state rather than left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stage_q  <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (zeroize) begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
      state_q <= WIPE;
      if ((state_q == COLLECT) || (state_q == COMMIT)) begin
        err      <= 1'b1;
        err_code <= ERR_ZERO;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (par_ok) begin
              stage_q[DW-1:0] <= bus.wr_data;
              cnt_q           <= CNT_W'(1);
              tmo_q           <= '0;
              err             <= 1'b0;
              err_code        <= ERR_NONE;
              state_q         <= (N == 1) ? COMMIT : COLLECT;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_PARITY;
              state_q  <= WIPE;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            if (par_ok) begin
              stage_q[int'(cnt_q)*DW +: DW] <= bus.wr_data;
              cnt_q <= cnt_q + CNT_W'(1);
              tmo_q <= '0;
              if (last_word) state_q <= COMMIT;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_PARITY;
              state_q  <= WIPE;
            end
          end else if (timeout_hit) begin
            err      <= 1'b1;
            err_code <= ERR_TMO;
            state_q  <= WIPE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        COMMIT: begin
          state_q <= WIPE;
        end
        default: begin
          stage_q <= '0;
          cnt_q   <= '0;
          tmo_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_word_loader.sv
// Self-checking bench for key_word_loader (W=128, DW=32, TIMEOUT=8).
module tb_key_word_loader;

  localparam int W  = 128;
  localparam int DW = 32;
  localparam int N  = W / DW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           zeroize;
  logic           load;
  logic [W-1:0]   key_out;
  logic           busy;
  logic           err;
  logic [1:0]     err_code;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]  words [N];
  logic [W-1:0]   exp_key;

  key_word_loader_if #(.DW(DW)) bus ();

  key_word_loader #(.W(W), .DW(DW), .TIMEOUT(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .zeroize  (zeroize),
    .load     (load),
    .key_out  (key_out),
    .busy     (busy),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Odd parity: parity bit makes the byte plus its bit XOR to 1.
  function automatic logic [DW/8-1:0] good_par(input logic [DW-1:0] d);
    logic [DW/8-1:0] p;
    for (int i = 0; i < DW/8; i++) p[i] = ~(^d[8*i +: 8]);
    return p;
  endfunction

  task automatic random_key();
    for (int k = 0; k < N; k++) words[k] = $urandom;
    exp_key = {words[3], words[2], words[1], words[0]};
  endtask

  // Sends up to n_words back-to-back. bad_idx corrupts lane 0 parity of that word,
  // zero_last raises zeroize alongside the last word, zero_commit raises it in the load cycle.
  task automatic send(input int bad_idx, input bit zero_last, input bit zero_commit, input int n_words);
    for (int k = 0; k < n_words; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = words[k];
      bus.wr_par   = good_par(words[k]) ^ ((k == bad_idx) ? 4'b0001 : 4'b0000);
      zeroize      = zero_last && (k == N - 1);
      #1;
      check("ready_before_word", bus.wr_ready, !(zero_last && (k == N - 1)));
      check("no_load_while_collecting", load, 0);
      check("key_hidden_while_collecting", key_out, 0);
      @(negedge clk);
      if (k == 0 && bad_idx != 0) check("err_cleared_on_first_word", {err, err_code}, 0);
      if (k == bad_idx) begin
        check("parity_err", {err, err_code}, 3'b101);
        check("parity_wipe_busy", busy, 1);
        check("parity_no_load", load, 0);
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("parity_back_idle", {busy, bus.wr_ready, load}, 3'b010);
        return;
      end
      if (zero_last && k == N - 1) begin
        check("zlast_no_load", load, 0);
        check("zlast_err", {err, err_code}, 3'b111);
        check("zlast_wipe_busy", busy, 1);
        bus.wr_valid = 1'b0;
        zeroize      = 1'b0;
        @(negedge clk);
        check("zlast_back_idle", {busy, bus.wr_ready, load}, 3'b010);
        return;
      end
      bus.wr_valid = 1'b0;
    end
    if (n_words < N) return;
    if (zero_commit) begin
      zeroize = 1'b1;
      #1;
      check("zcommit_load_masked", load, 0);
      check("zcommit_key_masked", key_out, 0);
      @(negedge clk);
      zeroize = 1'b0;
      #1;
      check("zcommit_err", {err, err_code}, 3'b111);
      check("zcommit_wipe", {busy, load, bus.wr_ready}, 3'b100);
      @(negedge clk);
      check("zcommit_back_idle", {busy, bus.wr_ready}, 2'b01);
      return;
    end
    check("load_pulse", load, 1);
    check("key_value", key_out, exp_key);
    check("no_err_on_load", {err, err_code}, 0);
    check("ready_low_in_load", bus.wr_ready, 0);
    @(negedge clk);
    check("load_one_cycle", load, 0);
    check("key_cleared_after_load", key_out, 0);
    check("ready_low_in_wipe", {busy, bus.wr_ready}, 2'b10);
    @(negedge clk);
    check("ready_after_load_plus2", {busy, bus.wr_ready}, 2'b01);
  endtask

  initial begin
    rst_n        = 1'b0;
    zeroize      = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_par   = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {load, busy, err, err_code}, 0);
    check("reset_key", key_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.wr_ready, 1);

    // Clean load with the fixed incrementing-byte key.
    words[0] = 32'h03020100; words[1] = 32'h07060504;
    words[2] = 32'h0B0A0908; words[3] = 32'h0F0E0D0C;
    exp_key  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    send(-1, 1'b0, 1'b0, N);

    // Parity failure on word 2, then a clean transfer that clears the error.
    random_key(); send(2, 1'b0, 1'b0, N);
    random_key(); send(-1, 1'b0, 1'b0, N);

    // Inter-word timeout: the error must appear after exactly TIMEOUT idle cycles.
    random_key(); send(-1, 1'b0, 1'b0, 2);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("tmo_not_yet", {busy, err}, 2'b10);
    end
    @(negedge clk);
    check("tmo_err", {err, err_code}, 3'b110);
    check("tmo_no_load", {load, bus.wr_ready}, 2'b00);
    @(negedge clk);
    check("tmo_back_idle", {busy, bus.wr_ready}, 2'b01);

    // Zeroize in the commit cycle, then zeroize alongside the last word.
    random_key(); send(-1, 1'b0, 1'b1, N);
    random_key(); send(-1, 1'b1, 1'b0, N);

    // Zeroize while idle wipes but flags nothing.
    random_key(); send(-1, 1'b0, 1'b0, N);
    zeroize = 1'b1;
    #1;
    check("zidle_ready_low", bus.wr_ready, 0);
    @(negedge clk);
    zeroize = 1'b0;
    #1;
    check("zidle_no_err", {err, err_code, busy}, 4'b0001);
    @(negedge clk);
    check("zidle_back_idle", busy, 0);

    // Asynchronous reset in the middle of a transfer.
    random_key(); send(-1, 1'b0, 1'b0, 2);
    check("collect_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {load, busy, err, err_code}, 0);
    check("async_reset_key", key_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    random_key(); send(-1, 1'b0, 1'b0, N);

    // Random mix of clean and parity-corrupted transfers.
    for (int t = 0; t < 8; t++) begin
      int b;
      b = $urandom_range(0, 5);
      random_key();
      send((b >= N) ? -1 : b, 1'b0, 1'b0, N);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_word_loader.md
Name: key_word_loader

Overview:
- Upstream feeder for the zeroizable key register.
- Accepts a key as a stream of DW-bit firmware/bus words over a valid/ready handshake and checks per-byte odd parity on every word.
- Assembles the words into a W-bit staging buffer. Issues a single-cycle load pulse with the full key to the downstream key register only when every word arrived clean and in time.
- Any error, timeout or zeroize wipes the staging buffer without loading.

Parameters:
- W, 128, key width in bits; must be a multiple of DW.
- DW, 32, input word width; must be a multiple of 8.
- TIMEOUT, 255, maximum idle cycles between consecutive accepted words within one transfer.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- wr_valid  in  1  word valid.
- wr_ready  out  1  block can accept a word.
- wr_data  in  DW  key word. Least-significant word first.
- wr_par  in  DW/8  odd-parity bit per byte. Lane i covers wr_data[8i+:8].
- zeroize  in  1  wipe request (soft zeroize or tamper, already combined).
- load  out  1  one-cycle strobe to the key register.
- key_out  out  W  assembled key. Nonzero only while load=1.
- busy  out  1  transfer in progress (state != IDLE).
- err  out  1  sticky error flag.
- err_code  out  2  00 none, 01 parity, 10 timeout, 11 zeroized mid-transfer.

Behaviour:
- N = W/DW words per key. Word k (0-based) lands in buffer bits [DW*k +: DW].
- Accept occurs when wr_valid & wr_ready at a rising edge.
- Reset (async): state=IDLE, buffer=0, word count=0, timeout counter=0, err=0, err_code=00. Outputs: load=0, key_out=0, wr_ready=1 (after reset release), busy=0.
- Word parity is good iff, for every lane i, XOR of {wr_par[i], wr_data[8i+:8]} = 1.
- IDLE
  - wr_ready=1.
  - Accepted good word: store as word 0, count=1, clear err/err_code, go COLLECT. If N=1, go COMMIT instead.
  - Accepted bad word: err=1, err_code=01, go WIPE.
- COLLECT
  - wr_ready=1. The timeout counter increments each cycle without an accept and resets to 0 on an accept.
  - Good word accepted: store at index count, count++. If that was word N-1, go COMMIT.
  - Bad word accepted: err=1, err_code=01, go WIPE. The word is not stored.
  - Counter reaches TIMEOUT with no accept in that cycle: err=1, err_code=10, go WIPE.
- COMMIT (exactly 1 cycle)
  - wr_ready=0.
  - load=1 and key_out=buffer, both gated combinationally by ~zeroize.
  - Go WIPE.
- WIPE (exactly 1 cycle)
  - wr_ready=0. Buffer, count and timeout counter cleared to 0.
  - Go IDLE.
- zeroize has priority over everything, in any state.
  - No word is accepted; wr_ready is forced to 0 while zeroize=1.
  - No load is issued.
  - Next state is WIPE.
  - If state was COLLECT, or COMMIT, set err=1, err_code=11.
  - zeroize in IDLE or WIPE sets no error.
- Latency: load is asserted the cycle after the edge that accepted word N-1. The next transfer's first word can be accepted 2 cycles after load.
- key_out is 0 in every cycle where load=0. The key never lingers on the output.
- err/err_code hold until the first word of the next transfer is accepted, or until reset.
- busy = (state != IDLE).

Test Plan:
- Clean load: 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with correct parity, back-to-back. Required: load=1 for exactly one cycle, the cycle after the 4th accept, with key_out=0x0F0E0D0C_0B0A0908_07060504_03020100. key_out=0 the cycle after. wr_ready=1 again 2 cycles after load. err=0.
- Parity fail on word 2 (flip wr_par[0]): no load pulse; err=1, err_code=01; buffer=0 after WIPE. A subsequent clean transfer loads correctly and clears err on its first accept.
- Timeout with TIMEOUT=8: accept 2 words, then hold wr_valid=0 for 8 cycles. Required: err_code=10, no load, back in IDLE within 2 further cycles.
- Zeroize during COMMIT: raise zeroize in the load cycle. Required: load=0, key_out=0, err_code=11, next state WIPE.
- Zeroize coincident with the last word (wr_valid=1): word not accepted (wr_ready=0), no load, err_code=11.
- Async reset asserted mid-COLLECT: all outputs reset immediately without waiting for a clock edge; the next transfer starts at word index 0.
